// File: rtl/shift_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_req_arbiter_if
//  Description : Request/result bundle between the requesters, the shared
//                shifter arbiter and the downstream consumer of results.
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_req_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int SW  = $clog2(WIDTH);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_din;
  logic [NREQ*SW-1:0]    req_shamt;
  logic [NREQ*3-1:0]     req_mode;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_err;

  // Requester/consumer side
  modport master (
    output req_valid, req_din, req_shamt, req_mode, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_din, req_shamt, req_mode, res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );
endinterface
`default_nettype wire

// File: rtl/shift_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_req_arbiter
//  Description : Round-robin arbiter sharing one combinational barrel shifter
//                among NREQ requesters; one op per cycle, registered
//                valid/ready result tagged with the requester index.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_req_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  shift_req_arbiter_if.slave bus
);
  localparam int SW  = $clog2(WIDTH);
  localparam int IDW = $clog2(NREQ);

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;
  logic             r_res_err;
  logic [IDW-1:0]   r_rr_ptr;

  logic             w_can_acc;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_accept;
  logic [IDW-1:0]   w_next_ptr;

  logic [WIDTH-1:0]   w_din;
  logic [SW-1:0]      w_shamt;
  logic [2:0]         w_mode;
  logic [SW-1:0]      w_rot_amt;
  logic [2*WIDTH-1:0] w_rot_ext;
  logic [WIDTH-1:0]   w_shift;

  // The result slot can take a new op if it is empty or draining this cycle.
  assign w_can_acc = !r_res_valid || bus.res_ready;

  // Round-robin search starting at r_rr_ptr; nothing is granted during reset.
  always_comb begin
    int             pos;
    logic [IDW-1:0] idx;
    w_grant     = '0;
    w_grant_idx = '0;
    pos         = 0;
    idx         = '0;
    if (!rst && w_can_acc) begin
      for (int k = 0; k < NREQ; k++) begin
        pos = int'(r_rr_ptr) + k;
        if (pos >= NREQ) begin
          pos = pos - NREQ;
        end
        idx = IDW'(pos);
        if ((w_grant == '0) && bus.req_valid[idx]) begin
          w_grant[idx] = 1'b1;
          w_grant_idx  = idx;
        end
      end
    end
  end

  assign w_accept      = |w_grant;
  assign bus.req_ready = w_grant;
  assign w_next_ptr    = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // Route the granted requester's operand, shift amount and mode to the shifter.
  always_comb begin
    w_din   = '0;
    w_shamt = '0;
    w_mode  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_din   = bus.req_din[i*WIDTH +: WIDTH];
        w_shamt = bus.req_shamt[i*SW +: SW];
        w_mode  = bus.req_mode[i*3 +: 3];
      end
    end
  end

  // Rotates share one double-width right shift. A left rotate by s equals a
  // right rotate by (-s mod WIDTH), so s==0 never produces a WIDTH-bit shift.
  // The upper half of the same shift is exactly din>>s, reused for SRL.
  assign w_rot_amt = (w_mode == 3'd4) ? (SW'(0) - w_shamt) : w_shamt;
  assign w_rot_ext = {w_din, w_din} >> w_rot_amt;

  // Shift datapath; illegal modes pass the operand through unchanged.
  always_comb begin
    w_shift = w_din;
    case (w_mode)
      3'd0, 3'd2: w_shift = w_din << w_shamt;
      3'd1:       w_shift = w_rot_ext[2*WIDTH-1:WIDTH];
      3'd3:       w_shift = WIDTH'($signed(w_din) >>> w_shamt);
      3'd4, 3'd5: w_shift = w_rot_ext[WIDTH-1:0];
      default:    w_shift = w_din;
    endcase
  end

  // Result register and round-robin pointer; an in-flight result is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_shift;
      r_res_id    <= w_grant_idx;
      r_res_err   <= w_mode[2] & w_mode[1];
      r_rr_ptr    <= w_next_ptr;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign bus.res_err   = r_res_err;
endmodule
`default_nettype wire

// File: tb/tb_shift_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_req_arbiter
//  Description : Scoreboard bench for shift_req_arbiter: directed scenarios
//                followed by random traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_req_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int SW    = 5;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  shift_req_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  shift_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_ptr    = 0;
  bit          m_valid  = 1'b0;
  logic [31:0] din_a  [NREQ];
  logic [4:0]  sh_a   [NREQ];
  logic [2:0]  mode_a [NREQ];
  logic [3:0]  pending = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shifter built from single-bit steps.
  function automatic logic [31:0] ref_f(input logic [31:0] d, input int s, input int m);
    logic [31:0] r;
    r = d;
    case (m)
      0, 2: r = d << s;
      1:    r = d >> s;
      3:    for (int k = 0; k < s; k++) r = {r[31], r[31:1]};
      4:    for (int k = 0; k < s; k++) r = {r[30:0], r[31]};
      5:    for (int k = 0; k < s; k++) r = {r[0], r[31:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // One cycle: drive requests, check grant and slot state against the model,
  // and push the expected result of any accept.
  task automatic step(input logic [3:0] v, input logic rr);
    logic [3:0] g;
    int         idx;
    int         p;
    res_t       e;
    @(negedge clk);
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_din[i*WIDTH +: WIDTH] = din_a[i];
      bus.req_shamt[i*SW +: SW]     = sh_a[i];
      bus.req_mode[i*3 +: 3]        = mode_a[i];
    end
    bus.res_ready = rr;
    #1;
    chk("res_valid", {31'b0, bus.res_valid}, {31'b0, m_valid});
    g   = 4'b0;
    idx = -1;
    if (!m_valid || rr) begin
      for (int k = 0; k < NREQ; k++) begin
        p = (m_ptr + k) % NREQ;
        if (idx < 0 && v[p[1:0]]) idx = p;
      end
    end
    if (idx >= 0) g[idx[1:0]] = 1'b1;
    chk("req_ready", {28'b0, bus.req_ready}, {28'b0, g});
    if (idx >= 0) begin
      e.data = ref_f(din_a[idx], int'(sh_a[idx]), int'(mode_a[idx]));
      e.id   = idx[1:0];
      e.err  = (mode_a[idx] > 3'd5);
      exp_q.push_back(e);
      m_ptr   = (idx + 1) % NREQ;
      m_valid = 1'b1;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    pending = v & ~g;
  endtask

  // Literal check of the result register just after the next edge.
  task automatic peek(input string tag, input logic [31:0] d, input logic [1:0] id, input logic err);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'b0, bus.res_valid}, 32'd1);
    chk({tag, "_data"}, bus.res_data, d);
    chk({tag, "_id"}, {30'b0, bus.res_id}, {30'b0, id});
    chk({tag, "_err"}, {31'b0, bus.res_err}, {31'b0, err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 4'b0;
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = 0;
    m_valid = 1'b0;
    pending = 4'b0;
    exp_q.delete();
  endtask

  // Monitor: compare the presented result with the oldest expectation; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.res_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: res_valid=1 id=%0d data=0x%08h, none expected",
                   bus.res_id, bus.res_data);
        end else begin
          chk("mon_data", bus.res_data, exp_q[0].data);
          chk("mon_id", {30'b0, bus.res_id}, {30'b0, exp_q[0].id});
          chk("mon_err", {31'b0, bus.res_err}, {31'b0, exp_q[0].err});
          if (bus.res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s2_exp [5];
    logic [4:0]  s2_sh  [5];
    logic [2:0]  s2_md  [5];
    logic [3:0]  v;

    for (int i = 0; i < NREQ; i++) begin
      din_a[i]  = 32'b0;
      sh_a[i]   = 5'b0;
      mode_a[i] = 3'b0;
    end
    bus.req_din   = '0;
    bus.req_shamt = '0;
    bus.req_mode  = '0;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    rst           = 1'b1;

    // Reset state, with requests pending while rst is high.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_id", {30'b0, bus.res_id}, 32'd0);
    chk("rst_res_err", {31'b0, bus.res_err}, 32'd0);
    bus.req_valid = 4'b0;
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: requester 0 alone, rotate left.
    din_a[0] = 32'h8000_0001; sh_a[0] = 5'd4; mode_a[0] = 3'd4;
    step(4'b0001, 1'b1);
    peek("s1", 32'h0000_0018, 2'd0, 1'b0);
    step(4'b0000, 1'b1);

    // Scenario 2: mode coverage through requester 1, back to back.
    s2_md[0] = 3'd1; s2_sh[0] = 5'd8;  s2_exp[0] = 32'h00F0_0000;
    s2_md[1] = 3'd3; s2_sh[1] = 5'd8;  s2_exp[1] = 32'hFFF0_0000;
    s2_md[2] = 3'd0; s2_sh[2] = 5'd8;  s2_exp[2] = 32'h0000_0000;
    s2_md[3] = 3'd5; s2_sh[3] = 5'd0;  s2_exp[3] = 32'hF000_0000;
    s2_md[4] = 3'd5; s2_sh[4] = 5'd31; s2_exp[4] = 32'hE000_0001;
    for (int t = 0; t < 5; t++) begin
      din_a[1] = 32'hF000_0000; sh_a[1] = s2_sh[t]; mode_a[1] = s2_md[t];
      step(4'b0010, 1'b1);
      peek("s2", s2_exp[t], 2'd1, 1'b0);
    end
    step(4'b0000, 1'b1);

    // Scenario 5: illegal mode is passed through and flagged, then cleared.
    din_a[2] = 32'h1234_5678; sh_a[2] = 5'd3; mode_a[2] = 3'd6;
    step(4'b0100, 1'b1);
    peek("s5_illegal", 32'h1234_5678, 2'd2, 1'b1);
    din_a[2] = 32'h0000_0001; sh_a[2] = 5'd3; mode_a[2] = 3'd0;
    step(4'b0100, 1'b1);
    peek("s5_legal", 32'h0000_0008, 2'd2, 1'b0);
    step(4'b0000, 1'b1);

    // Scenario 3: all requesters valid from reset -> strict rotation.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      din_a[i] = $urandom; sh_a[i] = 5'($urandom_range(0, 31)); mode_a[i] = 3'($urandom_range(0, 5));
    end
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 1'b1);
      chk("s3_grant", {28'b0, bus.req_ready}, 32'd1 << (c % 4));
    end

    // Scenario 4: backpressure holds the result and blocks grants.
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b0);
      chk("s4_blocked", {28'b0, bus.req_ready}, 32'd0);
    end
    step(4'b1111, 1'b1);
    chk("s4_resume_grant", {28'b0, bus.req_ready}, 32'd1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Scenario 6: asynchronous reset while a result is held and rr_ptr is 2.
    din_a[1] = 32'hA5A5_0F0F; sh_a[1] = 5'd7; mode_a[1] = 3'd5;
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("s6_pre_valid", {31'b0, bus.res_valid}, 32'd1);
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("s6_async_ready", {28'b0, bus.req_ready}, 32'd0);
    chk("s6_async_data", bus.res_data, 32'd0);
    chk("s6_async_id", {30'b0, bus.res_id}, 32'd0);
    @(negedge clk);
    bus.req_valid = 4'b0;
    rst     = 1'b0;
    m_ptr   = 0;
    m_valid = 1'b0;
    pending = 4'b0;
    exp_q.delete();
    step(4'b1010, 1'b1);
    chk("s6_first_grant", {28'b0, bus.req_ready}, 32'd2);
    step(4'b0000, 1'b1);

    // Random traffic with requester stability and random backpressure.
    for (int c = 0; c < 400; c++) begin
      v = pending;
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i]) begin
          din_a[i]  = $urandom;
          sh_a[i]   = 5'($urandom_range(0, 31));
          mode_a[i] = 3'($urandom_range(0, 7));
          v[i]      = ($urandom_range(0, 1) == 1);
        end
      end
      step(v, ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    @(negedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
